uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance between NUM_REQ byte-stream requesters using round-robin arbitration with packet locking.
- A granted requester keeps the transmitter until it presents a byte flagged last, so multi-byte messages are never interleaved.
- Sits between the application sources (stack replay, status reporter, echo path) and the uart_tx enable/busy/data interface.

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/rr_priority_select.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx round-robin arbiter: FSM state encoding and
// the requester-index width helper.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        HOLD    = 3'd5
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating priority encoder: picks the first set bit of req, starting at ptr and
// wrapping around. Purely combinational.
module rr_priority_select
    import uart_arb_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    int unsigned    pos;
    logic [IDW-1:0] cand;

    // Scan from the farthest offset down to ptr itself so the nearest request wins.
    always_comb begin
        found = |req;
        idx   = '0;
        pos   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos  = (32'(ptr) + N - 1 - k) % N;
            cand = IDW'(pos);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte-stream requesters: round-robin between
// packets, with the grant locked to one requester until it sends its last byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned LOCK_TIMEOUT = 0
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            uart_tx_busy,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    output logic [id_w(NUM_REQ)-1:0]        grant_id,
    output logic                            grant_active,
    output logic                            lock_dropped
);

    localparam int unsigned ID_W = id_w(NUM_REQ);
    localparam int unsigned TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [ID_W-1:0] ID_MAX  = ID_W'(NUM_REQ - 1);

    arb_state_e        state;
    logic [ID_W-1:0]   rr_ptr;
    logic              last_q;
    logic [TO_W-1:0]   to_cnt;
    logic              sel_found;
    logic [ID_W-1:0]   sel_idx;
    logic [ID_W-1:0]   next_ptr;

    logic [PAYLOAD_BITS-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    assign next_ptr = (grant_id == ID_MAX) ? '0 : grant_id + 1'b1;

    rr_priority_select #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_select (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            req_ready    <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            last_q       <= 1'b0;
            lock_dropped <= 1'b0;
            to_cnt       <= '0;
        end else begin
            req_ready    <= '0;
            lock_dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id     <= sel_idx;
                        grant_active <= 1'b1;
                        req_ready    <= NUM_REQ'(1) << sel_idx;
                        state        <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    uart_tx_data <= data_arr[grant_id];
                    last_q       <= req_last[grant_id];
                    uart_tx_en   <= !uart_tx_busy;
                    state        <= SEND;
                end
                SEND: begin
                    // The strobe is registered, so it is launched only after seeing busy low.
                    if (uart_tx_en) begin
                        uart_tx_en <= 1'b0;
                        state      <= WAIT_HI;
                    end else if (!uart_tx_busy) begin
                        uart_tx_en <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (uart_tx_busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        if (last_q) begin
                            grant_active <= 1'b0;
                            rr_ptr       <= next_ptr;
                            state        <= IDLE;
                        end else begin
                            to_cnt <= '0;
                            state  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (req_valid[grant_id]) begin
                        req_ready <= NUM_REQ'(1) << grant_id;
                        to_cnt    <= '0;
                        state     <= ACCEPT;
                    end else if (LOCK_TIMEOUT != 0 && to_cnt == TO_LAST) begin
                        lock_dropped <= 1'b1;
                        grant_active <= 1'b0;
                        rr_ptr       <= next_ptr;
                        to_cnt       <= '0;
                        state        <= IDLE;
                    end else if (LOCK_TIMEOUT != 0) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four requesters fed from byte queues and a
// uart_tx stand-in that stays busy for a fixed number of cycles per strobe.
module tb_uart_tx_arbiter;

    localparam int unsigned NR       = 4;
    localparam int unsigned PB       = 8;
    localparam int unsigned TO       = 16;
    localparam int unsigned BUSY_LEN = 4;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR*PB-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            uart_tx_busy;
    logic            uart_tx_en;
    logic [PB-1:0]   uart_tx_data;
    logic [1:0]      grant_id;
    logic            grant_active;
    logic            lock_dropped;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .PAYLOAD_BITS (PB),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .lock_dropped (lock_dropped)
    );

    // Requester queues: valid while unconsumed entries remain; a ready pops one.
    logic [PB-1:0] src_data  [NR][64];
    logic          src_lastf [NR][64];
    logic [5:0]    src_len   [NR] = '{default: '0};
    logic [5:0]    src_idx   [NR] = '{default: '0};

    for (genvar g = 0; g < NR; g++) begin : g_src
        assign req_valid[g]          = src_idx[g] != src_len[g];
        assign req_last[g]           = src_lastf[g][src_idx[g]];
        assign req_data[g*PB +: PB]  = src_data[g][src_idx[g]];
        always @(posedge clk) begin
            if (req_ready[g]) src_idx[g] <= src_idx[g] + 6'd1;
        end
    end

    // uart_tx stand-in
    int   bcnt;
    logic force_busy = 1'b0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) bcnt <= 0;
        else if (uart_tx_en && bcnt == 0) bcnt <= BUSY_LEN;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign uart_tx_busy = (bcnt != 0) || force_busy;

    logic [PB-1:0] tx_log [$];
    int tx_rd = 0;
    int en_busy_viol = 0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resetn && uart_tx_en) begin
            tx_log.push_back(uart_tx_data);
            if (uart_tx_busy) en_busy_viol++;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input int r, input logic [PB-1:0] d, input logic l);
        src_data[r][src_len[r]]  = d;
        src_lastf[r][src_len[r]] = l;
        src_len[r] = src_len[r] + 6'd1;
    endtask

    task automatic expect_tx(input string tag, input logic [PB-1:0] d);
        int w = 0;
        while (tx_log.size() <= tx_rd && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (tx_log.size() > tx_rd) begin
            check(tag, 32'(tx_log[tx_rd]), 32'(d));
            tx_rd++;
        end else begin
            check({tag, "_timeout"}, 32'(tx_log.size()), 32'(tx_rd + 1));
        end
    endtask

    function automatic logic drained();
        for (int r = 0; r < NR; r++) if (src_idx[r] != src_len[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_quiet();
        int w = 0;
        while ((grant_active || uart_tx_busy || !drained()) && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) check("quiet_timeout", 32'(grant_active), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int en_hi;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_en", 32'(uart_tx_en), 32'd0);
        check("rst_data", 32'(uart_tx_data), 32'd0);
        check("rst_active", 32'(grant_active), 32'd0);

        // Single byte from requester 2
        @(negedge clk);
        push(2, 8'h41, 1'b1);
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'b0100);
        check("t1_en_early", 32'(uart_tx_en), 32'd0);
        @(negedge clk);
        check("t1_en", 32'(uart_tx_en), 32'd1);
        check("t1_data", 32'(uart_tx_data), 32'h41);
        check("t1_gid", 32'(grant_id), 32'd2);
        check("t1_active", 32'(grant_active), 32'd1);
        repeat (5) @(negedge clk);
        check("t1_active_hold", 32'(grant_active), 32'd1);
        @(negedge clk);
        check("t1_release", 32'(grant_active), 32'd0);
        expect_tx("t1_tx", 8'h41);
        wait_quiet();

        // Pointer now 3: requester 3 beats requester 0
        push(0, 8'h50, 1'b1);
        push(3, 8'h53, 1'b1);
        expect_tx("ptr_first", 8'h53);
        expect_tx("ptr_second", 8'h50);
        wait_quiet();

        // Round-robin from reset, two packets queued per requester
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        tx_rd = tx_log.size();
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            push(r, 8'h10 + 8'(r), 1'b1);
            push(r, 8'h20 + 8'(r), 1'b1);
        end
        for (int k = 0; k < NR; k++) expect_tx("rr_round1", 8'h10 + 8'(k));
        for (int k = 0; k < NR; k++) expect_tx("rr_round2", 8'h20 + 8'(k));
        wait_quiet();

        // Packet lock: requester 1 owns the uart for its three bytes
        push(0, 8'h01, 1'b1);
        expect_tx("lk_pre", 8'h01);
        wait_quiet();
        push(1, 8'hAA, 1'b0);
        push(1, 8'hBB, 1'b0);
        push(1, 8'hCC, 1'b1);
        push(0, 8'h02, 1'b1);
        push(3, 8'h03, 1'b1);
        expect_tx("lk_b0", 8'hAA);
        expect_tx("lk_b1", 8'hBB);
        expect_tx("lk_b2", 8'hCC);
        expect_tx("lk_next", 8'h03);
        expect_tx("lk_after", 8'h02);
        wait_quiet();

        // Busy held externally while in SEND
        push(2, 8'h77, 1'b1);
        @(negedge clk);
        check("bs_ready", 32'(req_ready), 32'b0100);
        force_busy = 1'b1;
        en_hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (uart_tx_en) en_hi++;
        end
        check("bs_stall_en", 32'(en_hi), 32'd0);
        force_busy = 1'b0;
        @(negedge clk);
        check("bs_fire", 32'(uart_tx_en), 32'd1);
        check("bs_data", 32'(uart_tx_data), 32'h77);
        expect_tx("bs_tx", 8'h77);
        wait_quiet();

        // Lock timeout: requester 2 abandons its packet, requester 0 waits
        push(2, 8'h5A, 1'b0);
        base = cyc;
        @(negedge clk);
        check("to_ready", 32'(req_ready), 32'b0100);
        push(0, 8'h0F, 1'b1);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (lock_dropped) break;
        end
        check("to_cycle", 32'(cyc - base), 32'd24);
        check("to_active", 32'(grant_active), 32'd0);
        @(negedge clk);
        check("to_pulse_end", 32'(lock_dropped), 32'd0);
        check("to_next_ready", 32'(req_ready), 32'b0001);
        expect_tx("to_b0", 8'h5A);
        expect_tx("to_b1", 8'h0F);
        wait_quiet();

        // Reset during WAIT_LO of a three-byte packet from requester 1
        push(1, 8'h61, 1'b0);
        push(1, 8'h62, 1'b0);
        push(1, 8'h63, 1'b1);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("ar_ready", 32'(req_ready), 32'd0);
        check("ar_en", 32'(uart_tx_en), 32'd0);
        check("ar_data", 32'(uart_tx_data), 32'd0);
        check("ar_gid", 32'(grant_id), 32'd0);
        check("ar_active", 32'(grant_active), 32'd0);
        check("ar_dropped", 32'(lock_dropped), 32'd0);
        for (int r = 0; r < NR; r++) src_len[r] = src_idx[r];
        @(negedge clk);
        resetn = 1'b1;
        tx_rd = tx_log.size();
        @(negedge clk);
        push(1, 8'hA1, 1'b1);
        push(0, 8'hA0, 1'b1);
        expect_tx("ar_first", 8'hA0);
        expect_tx("ar_second", 8'hA1);
        wait_quiet();

        check("en_while_busy", 32'(en_busy_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
